// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux block: mode encodings, counter width
// and a small wrap-around increment helper.
package scan_mux_pkg;

    // Operating modes selected by i_mode.
    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_RR     = 2'b01,
        MODE_PRIO   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // Width of the downstream acceptance counter.
    localparam int COUNT_W = 16;

    // Increment v modulo n (v is assumed to be in 0..n-1).
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/scan_mux_if.sv
// Channel-side and downstream-side signals of scan_mux, bundled in one
// interface. The slave modport is the mux itself, the master modport is
// whoever drives the channels and consumes the output.
interface scan_mux_if #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
);

    logic [N_CH*WIDTH-1:0]           i_data;
    logic [N_CH-1:0]                 i_valid;
    logic [N_CH-1:0]                 o_ready;
    logic [1:0]                      i_mode;
    logic [SEL_W-1:0]                i_ctrl;
    logic [WIDTH-1:0]                o_data;
    logic                            o_valid;
    logic                            i_ready;
    logic [SEL_W-1:0]                o_sel;
    logic [scan_mux_pkg::COUNT_W-1:0] o_count;

    modport slave (
        input  i_data, i_valid, i_mode, i_ctrl, i_ready,
        output o_ready, o_data, o_valid, o_sel, o_count
    );

    modport master (
        output i_data, i_valid, i_mode, i_ctrl, i_ready,
        input  o_ready, o_data, o_valid, o_sel, o_count
    );

endinterface

// File: rtl/scan_mux_rr_arbiter.sv
// Cyclic first-set search: returns the first requesting index found when
// scanning upward from ptr and wrapping past N_CH-1 back to 0. With ptr=0
// this degenerates to a fixed lowest-index priority search.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    // Scan all N_CH positions starting at ptr; keep the first hit.
    always_comb begin : search
        int unsigned idx;
        // NOTE: every output gets a default before the loop so no path
        // through this block can leave a value unassigned and infer a latch.
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = 32'(ptr) + 32'(i);
            if (idx >= 32'(N_CH)) begin
                idx = idx - 32'(N_CH);
            end
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// N_CH-to-1 channel multiplexer with a one-word registered output slot.
// A grant is chosen each cycle by mode (manual select, round robin, fixed
// priority or hold); the granted channel is accepted when the output slot
// is free and its word appears on o_data one cycle later.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input logic        i_clk,
    input logic        i_rst,
    scan_mux_if.slave  bus
);

    mode_e                mode;
    logic                 load_en;
    logic                 ctrl_ok;
    logic [SEL_W-1:0]     arb_ptr;
    logic [SEL_W-1:0]     arb_idx;
    logic                 arb_vld;
    logic [SEL_W-1:0]     gnt_idx;
    logic                 gnt_vld;
    logic [N_CH-1:0]      ready_vec;

    logic [WIDTH-1:0]     data_q;
    logic [SEL_W-1:0]     sel_q;
    logic                 valid_q;
    logic [COUNT_W-1:0]   count_q;
    logic [SEL_W-1:0]     ptr_q;

    assign mode    = mode_e'(bus.i_mode);
    // The output slot can take a new word when it is empty or being drained.
    assign load_en = !valid_q || bus.i_ready;
    assign ctrl_ok = (32'(bus.i_ctrl) < 32'(N_CH));
    // Priority mode shares the cyclic search, anchored at channel 0.
    assign arb_ptr = (mode == MODE_PRIO) ? '0 : ptr_q;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (bus.i_valid),
        .ptr     (arb_ptr),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Pick this cycle's grant according to the current mode.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        case (mode)
            MODE_MANUAL: begin
                if (ctrl_ok && bus.i_valid[bus.i_ctrl]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = bus.i_ctrl;
                end
            end
            MODE_RR, MODE_PRIO: begin
                gnt_vld = arb_vld;
                gnt_idx = arb_idx;
            end
            default: begin
                gnt_vld = 1'b0;
            end
        endcase
    end

    // One-hot accept toward the granted channel, suppressed during reset.
    always_comb begin
        ready_vec = '0;
        if (!i_rst && load_en && gnt_vld) begin
            ready_vec[gnt_idx] = 1'b1;
        end
    end

    // Output slot, acceptance counter and round-robin pointer.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments throughout, so every register here
        // updates from values sampled before the edge regardless of order.
        if (i_rst) begin
            // NOTE: the data and select registers are reset as well because
            // their reset value is visible on the outputs.
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            ptr_q   <= '0;
        end else begin
            if (valid_q && bus.i_ready) begin
                count_q <= count_q + 1'b1;
            end
            if (load_en) begin
                if (gnt_vld) begin
                    data_q  <= bus.i_data[gnt_idx*WIDTH +: WIDTH];
                    sel_q   <= gnt_idx;
                    valid_q <= 1'b1;
                    if (mode == MODE_RR) begin
                        ptr_q <= SEL_W'(wrap_inc(32'(gnt_idx), N_CH));
                    end
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.o_ready = ready_vec;
    assign bus.o_data  = data_q;
    assign bus.o_sel   = sel_q;
    assign bus.o_valid = valid_q;
    assign bus.o_count = count_q;

endmodule
